// File: rtl/ret_stack.sv
// Return-address stack: saves the PC on call/interrupt entry and presents the saved
// address on pop_data for the PC register's memout load path.
module ret_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0]      SpOne    = (AW+1)'(1);
    localparam logic [AW:0]      SpTwo    = (AW+1)'(2);
    localparam logic [AW:0]      SpFull   = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] EmptyTop = WIDTH'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      sp_q, sp_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic             ovf_set, unf_set;
    logic [AW:0]      sp_m1, sp_m2;

    assign sp_m1 = sp_q - SpOne;
    assign sp_m2 = sp_q - SpTwo;

    assign count     = sp_q;
    assign empty     = (sp_q == '0);
    assign full      = (sp_q == SpFull);
    assign pop_data  = top_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    always_comb begin
        sp_d      = sp_q;
        top_d     = top_q;
        mem_we    = 1'b0;
        mem_waddr = sp_q[AW-1:0];
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        unique case ({push, pop})
            2'b10: begin
                if (!full) begin
                    mem_we    = 1'b1;
                    mem_waddr = sp_q[AW-1:0];
                    top_d     = push_data;
                    sp_d      = sp_q + SpOne;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    sp_d  = sp_m1;
                    top_d = (sp_q >= SpTwo) ? mem_q[sp_m2[AW-1:0]] : EmptyTop;
                end else begin
                    unf_set = 1'b1;
                end
            end
            2'b11: begin
                // Return followed by call: overwrite the top entry in place.
                mem_we = 1'b1;
                top_d  = push_data;
                if (!empty) begin
                    mem_waddr = sp_m1[AW-1:0];
                end else begin
                    mem_waddr = '0;
                    sp_d      = SpOne;
                    unf_set   = 1'b1;
                end
            end
            default: ;
        endcase

        // A fresh error in the same cycle wins over clr_err.
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q  <= '0;
            top_q <= EmptyTop;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Array is deliberately not reset; reset only makes old entries unreachable.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= push_data;
        end
    end

endmodule

// File: tb/tb_ret_stack.sv
// Self-checking bench for ret_stack: directed test-plan steps followed by random
// traffic, all checked against a queue-based reference model.
module tb_ret_stack;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 3;

    logic             clock;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             clr_err;
    logic [WIDTH-1:0] pop_data;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    logic [WIDTH-1:0] stk[$];
    logic             m_ovf;
    logic             m_unf;

    ret_stack #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .AW   (AW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(push_data),
        .clr_err  (clr_err),
        .pop_data (pop_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                              input logic c, input logic r);
        logic e_ovf, e_unf;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        if (r) begin
            stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && !q) begin
                if (stk.size() < DEPTH) stk.push_back(d);
                else e_ovf = 1'b1;
            end else if (q && !p) begin
                if (stk.size() > 0) void'(stk.pop_back());
                else e_unf = 1'b1;
            end else if (p && q) begin
                if (stk.size() > 0) stk[stk.size()-1] = d;
                else begin
                    stk.push_back(d);
                    e_unf = 1'b1;
                end
            end
            m_ovf = e_ovf | (m_ovf & ~c);
            m_unf = e_unf | (m_unf & ~c);
        end
    endtask

    task automatic model_compare(input string tag);
        logic [WIDTH-1:0] exp_top;
        exp_top = (stk.size() > 0) ? stk[stk.size()-1] : 16'h0001;
        chk({tag, ".pop_data"}, 32'(pop_data), 32'(exp_top));
        chk({tag, ".count"}, 32'(count), 32'(stk.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(stk.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(stk.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic cycle(input string tag, input logic p, input logic q,
                         input logic [WIDTH-1:0] d, input logic c, input logic r);
        push      = p;
        pop       = q;
        push_data = d;
        clr_err   = c;
        reset     = r;
        @(posedge clock);
        #1;
        model_step(p, q, d, c, r);
        model_compare(tag);
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        reset   = 1'b0;
    endtask

    initial begin
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        clr_err   = 1'b0;
        reset     = 1'b1;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;

        // Reset then idle
        cycle("rst", 0, 0, 16'h0, 0, 1);
        cycle("idle", 0, 0, 16'h0, 0, 0);
        chk("rst_pop_data", 32'(pop_data), 32'h0001);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_flags", 32'({overflow, underflow}), 32'd0);

        // Three pushes, three pops
        cycle("p10", 1, 0, 16'h0010, 0, 0);
        cycle("p20", 1, 0, 16'h0020, 0, 0);
        cycle("p30", 1, 0, 16'h0030, 0, 0);
        chk("push3_top", 32'(pop_data), 32'h0030);
        chk("push3_count", 32'(count), 32'd3);
        cycle("pop1", 0, 1, 16'h0, 0, 0);
        chk("pop1_top", 32'(pop_data), 32'h0020);
        chk("pop1_count", 32'(count), 32'd2);
        cycle("pop2", 0, 1, 16'h0, 0, 0);
        chk("pop2_top", 32'(pop_data), 32'h0010);
        cycle("pop3", 0, 1, 16'h0, 0, 0);
        chk("pop3_top", 32'(pop_data), 32'h0001);
        chk("pop3_count", 32'(count), 32'd0);

        // Fill to DEPTH, then one more push overflows
        for (int i = 0; i < 9; i++) begin
            cycle("fill", 1, 0, 16'h0100 + 16'(i), 0, 0);
            if (i == 7) chk("fill8_full", 32'(full), 32'd1);
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_top", 32'(pop_data), 32'h0107);
        chk("ovf_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_top", 32'(pop_data), 32'h0107 - 32'(i));
            cycle("drain", 0, 1, 16'h0, 0, 0);
        end
        chk("drain_empty_top", 32'(pop_data), 32'h0001);
        cycle("clr_ovf", 0, 0, 16'h0, 1, 0);
        chk("clr_ovf_flag", 32'(overflow), 32'd0);

        // Underflow and clear priority
        cycle("unf_pop", 0, 1, 16'h0, 0, 0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_count", 32'(count), 32'd0);
        cycle("unf_clr_pop", 0, 1, 16'h0, 1, 0);
        chk("unf_set_wins", 32'(underflow), 32'd1);
        cycle("unf_clr", 0, 0, 16'h0, 1, 0);
        chk("unf_cleared", 32'(underflow), 32'd0);

        // Simultaneous push and pop
        cycle("r10", 1, 0, 16'h0010, 0, 0);
        cycle("r20", 1, 0, 16'h0020, 0, 0);
        cycle("replace", 1, 1, 16'h0055, 0, 0);
        chk("replace_count", 32'(count), 32'd2);
        chk("replace_top", 32'(pop_data), 32'h0055);
        cycle("replace_pop", 0, 1, 16'h0, 0, 0);
        chk("replace_below", 32'(pop_data), 32'h0010);
        cycle("replace_pop2", 0, 1, 16'h0, 0, 0);
        cycle("pp_empty", 1, 1, 16'h0055, 0, 0);
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_top", 32'(pop_data), 32'h0055);
        chk("pp_empty_unf", 32'(underflow), 32'd1);
        cycle("pp_pop", 0, 1, 16'h0, 1, 0);

        // Reset priority mid-sequence
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 0, 16'h0200 + 16'(i), 0, 0);
        chk("pre_rst_count", 32'(count), 32'd5);
        cycle("rst_push", 1, 0, 16'h0777, 0, 1);
        chk("rst_push_count", 32'(count), 32'd0);
        chk("rst_push_top", 32'(pop_data), 32'h0001);
        cycle("post_rst_pop", 0, 1, 16'h0, 0, 0);
        chk("post_rst_unf", 32'(underflow), 32'd1);

        // Random traffic, alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            logic p, q, c, r;
            op = $urandom_range(0, 9);
            if ((i / 50) % 2 == 0) begin
                p = (op < 6) || (op == 8);
                q = (op >= 6 && op < 9);
            end else begin
                p = (op < 2) || (op == 8);
                q = (op >= 2 && op < 9);
            end
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 99) < 2);
            cycle("rand", p, q, WIDTH'($urandom), c, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
